// File: rtl/minisys_io_pkg.sv
// Shared definitions for the minisys I/O controller: register offsets inside
// the I/O window, the bus FSM state type, the switch/LED width and an address
// decode helper.
package minisys_io_pkg;

    localparam int IO_W = 24;

    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_STAT = 12'h074;
    localparam logic [11:0] OFF_CTRL = 12'h078;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_t;

    // Word-granular match: the two byte-select bits are masked off both sides.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [11:0] off);
        logic [31:0] target;
        target = base + {20'd0, off};
        return (addr & ~32'h3) == (target & ~32'h3);
    endfunction

endpackage

// File: rtl/minisys_io_ctrl_if.sv
// Core data-bus port: single-outstanding request/acknowledge.
//   req/we/addr/wdata : driven by the core (master)
//   rdata/ack/err     : driven by the I/O controller (slave), valid with ack
interface minisys_io_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (output req, we, addr, wdata, input  rdata, ack, err);
    modport slave  (input  req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/minisys_io_ctrl_switch_debounce.sv
// Switch conditioning: 2-flop synchronizer per bit, then a candidate register
// with a stability counter. A value is committed to 'stable' once it has been
// seen unchanged for DEBOUNCE_CYCLES synchronized cycles.
//   clk, rst (async, active-low)
//   raw[23:0]    asynchronous board switches
//   stable[23:0] debounced value
//   commit       high during the cycle whose rising edge loads a new stable value
module switch_debounce
    import minisys_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IO_W-1:0] raw,
    output logic [IO_W-1:0] stable,
    output logic            commit
);

    localparam logic [15:0] COMMIT_AT = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_reg [IO_W];
    logic [IO_W-1:0] synced;
    logic [IO_W-1:0] cand_reg, cand_next;
    logic [15:0]     cnt_reg, cnt_next;
    logic [IO_W-1:0] stable_reg;

    genvar gi;
    generate
        for (gi = 0; gi < IO_W; gi++) begin : g_sync
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_reg[gi] <= 2'b00;
                end else begin
                    sync_reg[gi] <= {sync_reg[gi][0], raw[gi]};
                end
            end
            assign synced[gi] = sync_reg[gi][1];
        end
    endgenerate

    // The commit decision looks at the counter's next value so that the
    // stable register and the counter reaching DEBOUNCE_CYCLES-1 land on the
    // same edge (raw-to-commit = 2 + DEBOUNCE_CYCLES cycles).
    always_comb begin
        cand_next = cand_reg;
        cnt_next  = cnt_reg;
        if (synced != cand_reg) begin
            cand_next = synced;
            cnt_next  = 16'd0;
        end else if (cnt_reg != 16'hFFFF) begin
            cnt_next = cnt_reg + 16'd1;
        end
        commit = (cnt_next == COMMIT_AT) && (cand_next != stable_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_reg   <= '0;
            cnt_reg    <= 16'd0;
            stable_reg <= '0;
        end else begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_next;
            if (commit) begin
                stable_reg <= cand_next;
            end
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/minisys_io_ctrl.sv
// Memory-mapped I/O controller for the minisys core: LED output register,
// debounced switch input, sticky change flag and level interrupt behind a
// request/acknowledge bus.
//   clk, rst (async, active-low)
//   bus    : slave side of minisys_io_ctrl_if (req/we/addr/wdata in,
//            rdata/ack/err out, all outputs registered)
//   irq    : changed & irq_en, registered
//   switch : raw board switches
//   led    : LED drive
module minisys_io_ctrl
    import minisys_io_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] IO_BASE         = 32'hFFFFFC00
) (
    input  logic                  clk,
    input  logic                  rst,
    minisys_io_ctrl_if.slave      bus,
    output logic                  irq,
    input  logic [IO_W-1:0]       switch,
    output logic [IO_W-1:0]       led
);

    bus_state_t      state_reg;
    logic [31:0]     rdata_reg;
    logic            ack_reg;
    logic            err_reg;
    logic [IO_W-1:0] led_reg;
    logic            irq_en_reg;
    logic            changed_reg;
    logic            irq_reg;

    logic [IO_W-1:0] sw_stable;
    logic            sw_commit;

    logic            hit_led, hit_sw, hit_stat, hit_ctrl, mapped;
    logic            accept, stat_clear;
    logic [31:0]     rd_mux;

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .raw    (switch),
        .stable (sw_stable),
        .commit (sw_commit)
    );

    always_comb begin
        hit_led    = addr_hit(bus.addr, IO_BASE, OFF_LED);
        hit_sw     = addr_hit(bus.addr, IO_BASE, OFF_SW);
        hit_stat   = addr_hit(bus.addr, IO_BASE, OFF_STAT);
        hit_ctrl   = addr_hit(bus.addr, IO_BASE, OFF_CTRL);
        mapped     = hit_led | hit_sw | hit_stat | hit_ctrl;
        accept     = (state_reg == IDLE) && bus.req;
        stat_clear = accept && !bus.we && hit_stat;

        rd_mux = 32'd0;
        if (hit_led) begin
            rd_mux = {8'd0, led_reg};
        end else if (hit_sw) begin
            rd_mux = {8'd0, sw_stable};
        end else if (hit_stat) begin
            rd_mux = {31'd0, changed_reg};
        end else if (hit_ctrl) begin
            rd_mux = {31'd0, irq_en_reg};
        end
    end

    // Bus FSM with registered outputs. Requests seen in ACK are ignored, so
    // the core can at most complete one access every two cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            rdata_reg  <= 32'd0;
            ack_reg    <= 1'b0;
            err_reg    <= 1'b0;
            led_reg    <= '0;
            irq_en_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req) begin
                        ack_reg   <= 1'b1;
                        err_reg   <= !mapped;
                        rdata_reg <= bus.we ? 32'd0 : rd_mux;
                        if (bus.we && hit_led) begin
                            led_reg <= bus.wdata[IO_W-1:0];
                        end
                        if (bus.we && hit_ctrl) begin
                            irq_en_reg <= bus.wdata[0];
                        end
                        state_reg <= ACK;
                    end
                end
                ACK: begin
                    ack_reg   <= 1'b0;
                    err_reg   <= 1'b0;
                    rdata_reg <= 32'd0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A commit on the same edge as a STAT read wins, so no change is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            changed_reg <= 1'b0;
            irq_reg     <= 1'b0;
        end else begin
            changed_reg <= sw_commit | (changed_reg & !stat_clear);
            irq_reg     <= changed_reg & irq_en_reg;
        end
    end

    assign bus.rdata = rdata_reg;
    assign bus.ack   = ack_reg;
    assign bus.err   = err_reg;
    assign led       = led_reg;
    assign irq       = irq_reg;

endmodule
